data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving the load/store requests issued by the CPU's MEM stage. Accepts one request at a time over a valid/ready handshake and performs byte, half or word accesses with sign/zero extension. Returns each result after a fixed, parameterised latency, holding it until the CPU accepts it. Lets the pipeline be exercised against realistic non-single-cycle memory.

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_load_extend.sv | 21 ++
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the MEM stage:
// access-size encoding, responder FSM states and common widths.
package dmem_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(16);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Bytes touched by an access; the reserved encoding behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Load-data extension: takes four raw little-endian bytes and returns the
// byte/half/word result, sign- or zero-extended to 32 bits.
module load_extend
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
      SIZE_HALF: data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
      default:   data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind a valid/ready request/response pair with a
// fixed latency. Define DMEM_ALIGN_CHECK_EN to fault misaligned/reserved accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [1:0]      dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end
  if (INIT_FILE != "") begin : g_init_file
    $error("INIT_FILE preload is not available in this memory model");
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; a request is sampled only then, a response holds until then.

  logic [7:0] mem [DEPTH];

  dmem_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic                   lat_we, lat_uns;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [XLEN-1:0]        lat_wdata;
  logic [1:0]             lat_size;

  logic                   accept, commit;
  logic                   c_we, c_uns, c_fault;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic [XLEN-1:0]        c_wdata, c_raw, c_load, commit_rdata;
  logic [1:0]             c_size;
  logic [2:0]             c_nbytes;
  logic [ADDR_WIDTH-1:0]  c_byte_addr [4];
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[XLEN-1:ADDR_WIDTH];
  assign req_ready_o    = (state == ST_IDLE) | ((state == ST_RESP) & resp_ready_i);
  assign accept         = req_valid_i & req_ready_o;
  assign dbg_state_o    = state;

  // With LATENCY==1 the commit happens on the accept edge itself, so the
  // access is taken straight from the request inputs instead of the latches.
  always_comb begin
    if (state == ST_WAIT) begin
      c_we    = lat_we;
      c_uns   = lat_uns;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_size  = lat_size;
    end else begin
      c_we    = req_we_i;
      c_uns   = req_unsigned_i;
      c_addr  = req_addr_i[ADDR_WIDTH-1:0];
      c_wdata = req_wdata_i;
      c_size  = req_size_i;
    end
  end

  assign commit   = ((state == ST_WAIT) && (cnt == CNT_W'(1))) || (accept && (LATENCY == 1));
  assign c_nbytes = size_bytes(c_size);

  always_comb begin
    c_raw = '0;
    for (int i = 0; i < 4; i++) begin
      c_byte_addr[i] = c_addr + ADDR_WIDTH'(i);
      c_raw[8*i +: 8] = mem[c_byte_addr[i]];
    end
  end

  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    c_fault = ((c_size == SIZE_HALF) && c_addr[0])
            || ((c_size == SIZE_WORD) && (c_addr[1:0] != 2'b00))
            || (c_size == SIZE_RSVD);
`else
    c_fault = 1'b0;
`endif
  end

  load_extend u_load_extend (
    .raw_i      (c_raw),
    .size_i     (c_size),
    .unsigned_i (c_uns),
    .data_o     (c_load)
  );

  assign commit_rdata = (c_we | c_fault) ? '0 : c_load;

  // Memory contents survive reset; only the commit edge writes them.
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < c_nbytes) mem[c_byte_addr[i]] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      lat_we       <= 1'b0;
      lat_uns      <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= SIZE_BYTE;
    end else begin
      if (accept) begin
        lat_we    <= req_we_i;
        lat_uns   <= req_unsigned_i;
        lat_addr  <= req_addr_i[ADDR_WIDTH-1:0];
        lat_wdata <= req_wdata_i;
        lat_size  <= req_size_i;
        if (LATENCY == 1) begin
          state        <= ST_RESP;
          resp_valid_o <= 1'b1;
          resp_rdata_o <= commit_rdata;
          resp_err_o   <= c_fault;
        end else begin
          state        <= ST_WAIT;
          cnt          <= CNT_W'(LATENCY - 1);
          resp_valid_o <= 1'b0;
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_WAIT: begin
            if (cnt == CNT_W'(1)) begin
              state        <= ST_RESP;
              cnt          <= '0;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= commit_rdata;
              resp_err_o   <= c_fault;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_RESP: begin
            if (resp_ready_i) begin
              state        <= ST_IDLE;
              resp_valid_o <= 1'b0;
              resp_rdata_o <= '0;
              resp_err_o   <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed load/store cases plus random traffic
// against a byte-array reference model, checked through a response queue.
module tb_data_mem_responder;

  localparam int AW    = 17;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic        clk_i, rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i, resp_rdata_o;
  logic [1:0]  req_size_i, dbg_state;
  logic        resp_valid_o, resp_ready_i, resp_err_o;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic [7:0]  mem_m [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rdy_random = 1'b0;
  bit          resp_seen  = 1'b0;
  bit          have_hold  = 1'b0;
  logic [32:0] hold_val;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference model: byte array, returns {err, rdata}.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [1:0] size,
                                               input logic uns);
    int     n, a;
    bit     fault;
    longint v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a = int'(addr % DEPTH);
    fault = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    fault = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0) || size == 2'd3;
`endif
    if (fault) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[(a + i) % DEPTH] = 8'((wdata >> (8 * i)) & 32'hFF);
      return 33'h0;
    end
    v = 0;
    for (int i = 0; i < n; i++) begin
      int k;
      k = (a + i) % DEPTH;
      v += longint'(mem_m.exists(k) ? mem_m[k] : 8'h00) << (8 * i);
    end
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return {1'b0, 32'(v)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rst_i) begin
      acc_q.delete();
      resp_seen = 1'b0;
      have_hold = 1'b0;
    end else begin
      if (req_valid_i && req_ready_o) acc_q.push_back(cyc);
      if (resp_valid_o) begin
        if (!resp_seen) begin
          resp_seen = 1'b1;
          if (acc_q.size() == 0) fail_now("latency_no_accept");
          else check("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
        end
        if (have_hold) check("resp_stable", {resp_err_o, resp_rdata_o}, hold_val);
        if (resp_ready_i) begin
          if (exp_q.size() == 0) fail_now("resp_unexpected");
          else check("resp", {resp_err_o, resp_rdata_o}, exp_q.pop_front());
          resp_seen = 1'b0;
          have_hold = 1'b0;
        end else begin
          check("req_ready_stall", req_ready_o, 0);
          hold_val  = {resp_err_o, resp_rdata_o};
          have_hold = 1'b1;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rdy_random) begin
      #1;
      resp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input bit push);
    int k;
    if (push) exp_q.push_back(model_access(we, addr, wdata, size, uns));
    req_we_i       = we;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_valid_i    = 1'b1;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!req_ready_o && k < 1000);
    if (!req_ready_o) fail_now("req_accept_timeout");
    else begin
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while ((exp_q.size() != 0 || resp_valid_o) && k < 2000);
    if (exp_q.size() != 0 || resp_valid_o) fail_now("drain_timeout");
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_req_ready", req_ready_o, 1);
    check("reset_resp_valid", resp_valid_o, 0);
    check("reset_resp_rdata", resp_rdata_o, 0);
    check("reset_resp_err", resp_err_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Fill the regions that later loads touch.
    for (int a = 32'h100; a <= 32'h13C; a += 4) do_req(1, a, $urandom, 2'd2, 0, 1);
    do_req(1, 32'h1FFF8, $urandom, 2'd2, 0, 1);
    do_req(1, 32'h1FFFC, $urandom, 2'd2, 0, 1);
    do_req(1, 32'h0, $urandom, 2'd2, 0, 1);
    do_req(1, 32'h4, $urandom, 2'd2, 0, 1);
    drain();

    // Directed load/store and extension cases.
    do_req(1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 1);
    do_req(0, 32'h100, 32'h0, 2'd2, 0, 1);
    do_req(1, 32'h103, 32'h00000080, 2'd0, 0, 1);
    do_req(0, 32'h103, 32'h0, 2'd0, 0, 1);
    do_req(0, 32'h103, 32'h0, 2'd0, 1, 1);
    do_req(0, 32'h100, 32'h0, 2'd2, 0, 1);
    do_req(0, 32'h102, 32'h0, 2'd1, 0, 1);
    do_req(0, 32'h102, 32'h0, 2'd1, 1, 1);
    do_req(0, 32'h100, 32'h0, 2'd3, 0, 1);
    drain();

    // Response stall, then same-cycle accept when ready rises.
    resp_ready_i = 1'b0;
    do_req(0, 32'h100, 32'h0, 2'd2, 0, 1);
    k = 0;
    while (!resp_valid_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (!resp_valid_o) fail_now("stall_resp_timeout");
    fork
      do_req(0, 32'h103, 32'h0, 2'd0, 0, 1);
      begin
        repeat (5) @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
      end
    join
    drain();

    // Misaligned word store, read back bytewise (with wrap near the top).
    do_req(1, 32'h101, 32'h11223344, 2'd2, 0, 1);
    for (int a = 32'h101; a <= 32'h104; a++) do_req(0, a, 32'h0, 2'd0, 1, 1);
    do_req(1, 32'h1FFFE, 32'hA1B2C3D4, 2'd2, 0, 1);
    do_req(0, 32'h1FFFE, 32'h0, 2'd2, 0, 1);
    do_req(0, 32'h0, 32'h0, 2'd1, 1, 1);
    drain();

    // Reset while a store is waiting: store must be dropped.
    do_req(1, 32'h120, 32'hCAFEF00D, 2'd2, 0, 0);
    rst_i = 1'b1;
    #1;
    check("rst_wait_resp_valid", resp_valid_o, 0);
    check("rst_wait_req_ready", req_ready_o, 1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    do_req(0, 32'h120, 32'h0, 2'd2, 0, 1);
    drain();

    // Random traffic with random response back-pressure.
    rdy_random = 1'b1;
    for (int n = 0; n < 120; n++) begin
      logic [31:0] addr;
      int gap;
      if ($urandom_range(0, 3) == 0) addr = 32'h1FFF8 + $urandom_range(0, 7);
      else addr = 32'h100 + $urandom_range(0, 32'h3C);
      addr = addr | (32'($urandom_range(0, 32767)) << 17);
      do_req(1'($urandom_range(0, 1)), addr, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk_i);
        #1;
      end
    end
    rdy_random = 1'b0;
    @(posedge clk_i);
    #2 resp_ready_i = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
